br_resolve: RTL and testbench
=============================

Name: br_resolve

Overview:
- Branch/jump resolution unit in the execute stage; it is the producer side of the PC redirect interface.
- Evaluates conditional branches, JAL and JALR.
- Drives the one-cycle `taken_br` pulse and `br_tgt_pc` consumed by the PC register.
- Squashes wrong-path instructions for a fixed number of cycles after each redirect.

Parameters:
- XLEN, 32, datapath and address width.
- FLUSH_CYCLES, 2, cycles of wrong-path squash after a redirect. Legal range is at least 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  execute-stage instruction is valid this cycle
- is_br  input  1  conditional branch
- is_jal  input  1  JAL
- is_jalr  input  1  JALR
- funct3  input  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- cur_pc  input  XLEN  PC of the instruction
- rs1  input  XLEN  source operand 1
- rs2  input  XLEN  source operand 2
- imm  input  XLEN  sign-extended immediate
- taken_br  output  1  redirect pulse to the PC register
- br_tgt_pc  output  XLEN  redirect target
- link_valid  output  1  write-back of the link address is valid
- link_data  output  XLEN  cur_pc+4 for JAL/JALR
- flush  output  1  squash the fetch/decode stages
- accepted  output  1  instruction accepted, i.e. not squashed

Behaviour:
- Reset is asynchronous: on rst assertion, all outputs clear to 0 immediately and the FSM goes to IDLE.
- Accept condition: in_valid && state==IDLE. `accepted` is combinational and equals this condition.
- Control-flow decode:
  - No control op (is_br=is_jal=is_jalr=0) → no redirect.
  - More than one of is_br/is_jal/is_jalr set → priority jalr > jal > br.
- Condition evaluation:
  - BLT/BGE use a signed compare; BLTU/BGEU use an unsigned compare.
  - funct3 values 010 and 011 → not taken.
- Target computation, all modulo 2^XLEN (wrap-around is silent):
  - branch/JAL target = cur_pc+imm
  - JALR target = (rs1+imm) & ~1
- Latency: one cycle. An op accepted in cycle N that is taken, or any JAL/JALR, produces in cycle N+1:
  - taken_br=1 for exactly one cycle
  - br_tgt_pc = target, held until the next redirect
  - flush=1
- Link write-back: link_valid=1 and link_data=cur_pc+4 for one cycle at N+1 for JAL/JALR, registered.
- Not-taken branch: no taken_br, no flush, no link.
- FSM:
  - IDLE: a taken op is accepted → FLUSH, with cnt=FLUSH_CYCLES-1.
  - FLUSH: flush=1. If cnt==0 → IDLE; otherwise cnt decrements.
  - flush is therefore high for exactly FLUSH_CYCLES cycles, starting at N+1.
- Squashing:
  - in_valid during FLUSH is ignored: accepted=0, no redirect, no link.
  - An op arriving in the first cycle after the last flush cycle is accepted normally.
- Back-to-back taken ops are impossible, because the second op always falls in FLUSH.
- rst asserted mid-FLUSH: immediate IDLE. A pending taken_br/link is dropped.

Optional Feature:
- Macro: BR_MISALIGN_EN.
- When defined:
  - Extra output `misalign_exc` (1 bit), registered.
  - For a redirect with target[1:0]!=0: misalign_exc=1 at N+1, taken_br=0, flush still asserted, link still written.
- When undefined: no port; the target is issued as computed.

Decomposition:
- Shared package `rv_pkg`:
  - funct3 branch encodings (F3_BEQ…F3_BGEU)
  - XLEN default
  - FSM state typedef (IDLE, FLUSH)
- One natural sub-module, `br_cmp`: combinational compare taking funct3, rs1 and rs2 and producing `cond_true`.
- Target adders, FSM and output registers stay in `br_resolve`.

Test Plan:
- BEQ, rs1=rs2=5, cur_pc=0x100, imm=0x20 → cycle N+1: taken_br=1, br_tgt_pc=0x120, flush high 2 cycles, no link.
- BLT, rs1=0xFFFFFFFF, rs2=1 → taken. BLTU with the same operands → not taken: no taken_br, no flush.
- JALR, rs1=0x203, imm=0 → br_tgt_pc=0x202, link_data=cur_pc+4, link_valid one cycle. With BR_MISALIGN_EN: misalign_exc=1, taken_br=0.
- JAL at cur_pc=0x100, then in_valid held high: ops in the next 2 cycles give accepted=0 and no second redirect. The op in the 3rd cycle gives accepted=1.
- Wrap: cur_pc=0xFFFFFFF0, imm=0x20, JAL → br_tgt_pc=0x10.
- rst pulsed in the first FLUSH cycle → flush, taken_br and link_valid drop immediately. The next valid op is accepted.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V execute-stage definitions: branch funct3 encodings, default
// datapath width and the branch-resolution FSM state type.
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } br_state_e;

endpackage

// File: rtl/br_cmp.sv
// Combinational branch condition evaluator; reserved funct3 codes (010, 011)
// evaluate false.
module br_cmp
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond_true
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            F3_BEQ:  cond_true = eq;
            F3_BNE:  cond_true = !eq;
            F3_BLT:  cond_true = lt_s;
            F3_BGE:  cond_true = !lt_s;
            F3_BLTU: cond_true = lt_u;
            F3_BGEU: cond_true = !lt_u;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resolve.sv
// Execute-stage branch/jump resolution: registered PC redirect, link write-back
// and a fixed-length wrong-path squash. Define BR_MISALIGN_EN for misalign_exc.
module br_resolve
    import rv_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            is_br,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] cur_pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] imm,
    output logic            taken_br,
    output logic [XLEN-1:0] br_tgt_pc,
    output logic            link_valid,
    output logic [XLEN-1:0] link_data,
    output logic            flush,
`ifdef BR_MISALIGN_EN
    output logic            misalign_exc,
`endif
    output logic            accepted
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    br_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             cond_true;
    logic             is_link;
    logic             redirect;
    logic [XLEN-1:0]  tgt;
    logic [XLEN-1:0]  link_pc;

    br_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .cond_true (cond_true)
    );

    assign accepted = in_valid && (state == IDLE);
    assign is_link  = is_jal || is_jalr;
    assign redirect = accepted && (is_link || (is_br && cond_true));
    assign link_pc  = cur_pc + XLEN'(4);

    // JALR wins over JAL/branch; its target has bit 0 forced clear.
    always_comb begin
        tgt = cur_pc + imm;
        if (is_jalr) begin
            tgt    = rs1 + imm;
            tgt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            taken_br     <= 1'b0;
            br_tgt_pc    <= '0;
            link_valid   <= 1'b0;
            link_data    <= '0;
            flush        <= 1'b0;
`ifdef BR_MISALIGN_EN
            misalign_exc <= 1'b0;
`endif
        end else begin
            taken_br     <= 1'b0;
            link_valid   <= 1'b0;
`ifdef BR_MISALIGN_EN
            misalign_exc <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (redirect) begin
                        state     <= FLUSH;
                        cnt       <= CNT_W'(FLUSH_CYCLES - 1);
                        flush     <= 1'b1;
                        br_tgt_pc <= tgt;
`ifdef BR_MISALIGN_EN
                        // A misaligned target raises the exception instead of redirecting.
                        taken_br     <= (tgt[1:0] == 2'b00);
                        misalign_exc <= (tgt[1:0] != 2'b00);
`else
                        taken_br  <= 1'b1;
`endif
                        if (is_link) begin
                            link_valid <= 1'b1;
                            link_data  <= link_pc;
                        end
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_br_resolve.sv
// Directed self-checking bench for br_resolve (default FLUSH_CYCLES=2, XLEN=32).
module tb_br_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, is_br, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic [31:0] cur_pc, rs1, rs2, imm;
    logic        taken_br, link_valid, flush, accepted;
    logic [31:0] br_tgt_pc, link_data;
`ifdef BR_MISALIGN_EN
    logic        misalign_exc;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    br_resolve dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .is_br      (is_br),
        .is_jal     (is_jal),
        .is_jalr    (is_jalr),
        .funct3     (funct3),
        .cur_pc     (cur_pc),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .taken_br   (taken_br),
        .br_tgt_pc  (br_tgt_pc),
        .link_valid (link_valid),
        .link_data  (link_data),
        .flush      (flush),
`ifdef BR_MISALIGN_EN
        .misalign_exc (misalign_exc),
`endif
        .accepted   (accepted)
    );

    task automatic drive(input logic v, input logic b, input logic j, input logic jr,
                         input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] c, input logic [31:0] im);
        in_valid = v; is_br = b; is_jal = j; is_jalr = jr; funct3 = f3;
        cur_pc = pc; rs1 = a; rs2 = c; imm = im;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_in();
        rst = 1'b1;
        #1;
        total++; if (taken_br !== 1'b0) $display("FAIL reset_taken got=%b exp=0", taken_br); else pass_cnt++;
        total++; if (flush !== 1'b0) $display("FAIL reset_flush got=%b exp=0", flush); else pass_cnt++;
        total++; if (link_valid !== 1'b0) $display("FAIL reset_link got=%b exp=0", link_valid); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h0) $display("FAIL reset_tgt got=%h exp=0", br_tgt_pc); else pass_cnt++;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_beq();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20);
        #1;
        total++; if (accepted !== 1'b1) $display("FAIL beq_acc got=%b exp=1", accepted); else pass_cnt++;
        step();
        idle_in();
        total++; if (taken_br !== 1'b1) $display("FAIL beq_taken got=%b exp=1", taken_br); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h120) $display("FAIL beq_tgt got=%h exp=120", br_tgt_pc); else pass_cnt++;
        total++; if (flush !== 1'b1) $display("FAIL beq_flush1 got=%b exp=1", flush); else pass_cnt++;
        total++; if (link_valid !== 1'b0) $display("FAIL beq_link got=%b exp=0", link_valid); else pass_cnt++;
        step();
        total++; if (taken_br !== 1'b0) $display("FAIL beq_pulse got=%b exp=0", taken_br); else pass_cnt++;
        total++; if (flush !== 1'b1) $display("FAIL beq_flush2 got=%b exp=1", flush); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h120) $display("FAIL beq_hold got=%h exp=120", br_tgt_pc); else pass_cnt++;
        step();
        total++; if (flush !== 1'b0) $display("FAIL beq_flush3 got=%b exp=0", flush); else pass_cnt++;
    endtask

    task automatic test_signed_unsigned();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h10);
        step();
        idle_in();
        total++; if (taken_br !== 1'b1) $display("FAIL blt_taken got=%b exp=1", taken_br); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h210) $display("FAIL blt_tgt got=%h exp=210", br_tgt_pc); else pass_cnt++;
        step(); step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h10);
        #1;
        total++; if (accepted !== 1'b1) $display("FAIL bltu_acc got=%b exp=1", accepted); else pass_cnt++;
        step();
        idle_in();
        total++; if (taken_br !== 1'b0) $display("FAIL bltu_taken got=%b exp=0", taken_br); else pass_cnt++;
        total++; if (flush !== 1'b0) $display("FAIL bltu_flush got=%b exp=0", flush); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h210) $display("FAIL bltu_hold got=%h exp=210", br_tgt_pc); else pass_cnt++;
        // reserved funct3 with equal operands must not branch
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 32'h400, 32'd7, 32'd7, 32'h10);
        step();
        idle_in();
        total++; if (taken_br !== 1'b0) $display("FAIL f3_010_taken got=%b exp=0", taken_br); else pass_cnt++;
        // BGEU: 0xFFFFFFFF >= 1 unsigned
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h8);
        step();
        idle_in();
        total++; if (taken_br !== 1'b1) $display("FAIL bgeu_taken got=%b exp=1", taken_br); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h508) $display("FAIL bgeu_tgt got=%h exp=508", br_tgt_pc); else pass_cnt++;
        step(); step();
    endtask

    task automatic test_jalr();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h300, 32'h203, 32'h0, 32'h0);
        step();
        idle_in();
        total++; if (br_tgt_pc !== 32'h202) $display("FAIL jalr_tgt got=%h exp=202", br_tgt_pc); else pass_cnt++;
        total++; if (link_valid !== 1'b1) $display("FAIL jalr_link got=%b exp=1", link_valid); else pass_cnt++;
        total++; if (link_data !== 32'h304) $display("FAIL jalr_ldata got=%h exp=304", link_data); else pass_cnt++;
        total++; if (flush !== 1'b1) $display("FAIL jalr_flush got=%b exp=1", flush); else pass_cnt++;
`ifdef BR_MISALIGN_EN
        total++; if (taken_br !== 1'b0) $display("FAIL jalr_mis_taken got=%b exp=0", taken_br); else pass_cnt++;
        total++; if (misalign_exc !== 1'b1) $display("FAIL jalr_mis_exc got=%b exp=1", misalign_exc); else pass_cnt++;
`else
        total++; if (taken_br !== 1'b1) $display("FAIL jalr_taken got=%b exp=1", taken_br); else pass_cnt++;
`endif
        step();
        total++; if (link_valid !== 1'b0) $display("FAIL jalr_link_pulse got=%b exp=0", link_valid); else pass_cnt++;
        step();
    endtask

    task automatic test_squash();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0, 32'h40);
        #1;
        total++; if (accepted !== 1'b1) $display("FAIL sq_acc0 got=%b exp=1", accepted); else pass_cnt++;
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0, 32'h80);
        #1;
        total++; if (taken_br !== 1'b1) $display("FAIL sq_taken got=%b exp=1", taken_br); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h140) $display("FAIL sq_tgt got=%h exp=140", br_tgt_pc); else pass_cnt++;
        total++; if (accepted !== 1'b0) $display("FAIL sq_acc1 got=%b exp=0", accepted); else pass_cnt++;
        step();
        total++; if (accepted !== 1'b0) $display("FAIL sq_acc2 got=%b exp=0", accepted); else pass_cnt++;
        total++; if (taken_br !== 1'b0) $display("FAIL sq_noredir got=%b exp=0", taken_br); else pass_cnt++;
        total++; if (link_valid !== 1'b0) $display("FAIL sq_nolink got=%b exp=0", link_valid); else pass_cnt++;
        step();
        total++; if (accepted !== 1'b1) $display("FAIL sq_acc3 got=%b exp=1", accepted); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h140) $display("FAIL sq_hold got=%h exp=140", br_tgt_pc); else pass_cnt++;
        step();
        idle_in();
        total++; if (taken_br !== 1'b1) $display("FAIL sq_taken2 got=%b exp=1", taken_br); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h180) $display("FAIL sq_tgt2 got=%h exp=180", br_tgt_pc); else pass_cnt++;
        step(); step();
    endtask

    task automatic test_wrap_priority();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h20);
        step();
        idle_in();
        total++; if (br_tgt_pc !== 32'h10) $display("FAIL wrap_tgt got=%h exp=10", br_tgt_pc); else pass_cnt++;
        total++; if (link_data !== 32'hFFFF_FFF4) $display("FAIL wrap_ldata got=%h exp=fffffff4", link_data); else pass_cnt++;
        step(); step();
        // not-taken BNE alongside JAL: the jump wins
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b001, 32'h600, 32'd3, 32'd3, 32'h24);
        step();
        idle_in();
        total++; if (taken_br !== 1'b1) $display("FAIL prio_jal_taken got=%b exp=1", taken_br); else pass_cnt++;
        total++; if (br_tgt_pc !== 32'h624) $display("FAIL prio_jal_tgt got=%h exp=624", br_tgt_pc); else pass_cnt++;
        step(); step();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h200, 32'h1000, 32'h0, 32'h4);
        step();
        idle_in();
        total++; if (br_tgt_pc !== 32'h1004) $display("FAIL prio_jalr_tgt got=%h exp=1004", br_tgt_pc); else pass_cnt++;
        step(); step();
    endtask

    task automatic test_rst_mid_flush();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h700, 32'h0, 32'h0, 32'h8);
        step();
        idle_in();
        total++; if (taken_br !== 1'b1) $display("FAIL rstm_taken_pre got=%b exp=1", taken_br); else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total++; if (flush !== 1'b0) $display("FAIL rstm_flush got=%b exp=0", flush); else pass_cnt++;
        total++; if (taken_br !== 1'b0) $display("FAIL rstm_taken got=%b exp=0", taken_br); else pass_cnt++;
        total++; if (link_valid !== 1'b0) $display("FAIL rstm_link got=%b exp=0", link_valid); else pass_cnt++;
        step();
        rst = 1'b0;
        #1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h800, 32'd1, 32'd1, 32'h4);
        #1;
        total++; if (accepted !== 1'b1) $display("FAIL rstm_acc got=%b exp=1", accepted); else pass_cnt++;
        step();
        idle_in();
        total++; if (br_tgt_pc !== 32'h804) $display("FAIL rstm_tgt got=%h exp=804", br_tgt_pc); else pass_cnt++;
        step(); step();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_jalr();
        test_squash();
        test_wrap_priority();
        test_rst_mid_flush();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
